// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan controller
package seg_pkg;
    localparam int SEG_W = 7;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    typedef enum logic {PH_BLANK, PH_SHOW} phase_e;
endpackage

// File: rtl/hex2seven_seg.sv
// hex2seven_seg: nibble to active-low common-anode segment pattern, bits g..a
module hex2seven_seg
    import seg_pkg::*;
(
    input  logic [3:0]       hex_i,
    output logic [SEG_W-1:0] seg_n_o
);
    // full hex glyph table, segment low = lit
    always_comb begin
        seg_n_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_n_o = 7'h40;
            4'h1: seg_n_o = 7'h79;
            4'h2: seg_n_o = 7'h24;
            4'h3: seg_n_o = 7'h30;
            4'h4: seg_n_o = 7'h19;
            4'h5: seg_n_o = 7'h12;
            4'h6: seg_n_o = 7'h02;
            4'h7: seg_n_o = 7'h78;
            4'h8: seg_n_o = 7'h00;
            4'h9: seg_n_o = 7'h10;
            4'hA: seg_n_o = 7'h08;
            4'hB: seg_n_o = 7'h03;
            4'hC: seg_n_o = 7'h46;
            4'hD: seg_n_o = 7'h21;
            4'hE: seg_n_o = 7'h06;
            default: seg_n_o = 7'h0E;
        endcase
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of a common-anode seven-segment bank
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    lz_blank,
    output logic [SEG_W-1:0]        seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   dig_sel_n,
    output logic                    frame_done
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || SCAN_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES > SCAN_DIV - 1) begin : g_bad_param
        $error("seg_scan_ctrl: need NUM_DIGITS>=1, SCAN_DIV>=2, 1<=BLANK_CYCLES<=SCAN_DIV-1");
    end

    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d, disp_q, disp_d, upper;
    logic [SEG_W-1:0]        seg_q, seg_d, dec;
    logic                    dp_q, dp_d, fd_q, fd_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [3:0]              nib;
    logic                    slot_end, bnd, sup, lit;
    phase_e                  ph;

    hex2seven_seg u_dec (.hex_i(nib), .seg_n_o(dec));

    // slot/digit stepping, frame-aligned value swap, and the next pin pattern
    always_comb begin
        slot_end = cnt_q == CW'(SCAN_DIV - 1);
        bnd      = slot_end && idx_q == IW'(NUM_DIGITS - 1);
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        idx_d    = slot_end ? (bnd ? '0 : idx_q + 1'b1) : idx_q;
        pend_d   = load ? value : pend_q;
        disp_d   = bnd ? pend_d : disp_q;
        ph       = cnt_q < CW'(BLANK_CYCLES) ? PH_BLANK : PH_SHOW;
        nib      = disp_q[4*idx_q +: 4];
        upper    = disp_q >> (4 * idx_q);
        sup      = lz_blank && idx_q != '0 && upper == '0;
        lit      = ph == PH_SHOW && dig_en[idx_q] && !sup;
        seg_d    = lit ? dec : SEG_BLANK;
        dp_d     = ph == PH_SHOW ? ~dp[idx_q] : 1'b1;
        sel_d    = lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
        fd_d     = bnd;
    end

    // state and registered outputs; reset darkens the display immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            pend_q <= '0;
            disp_q <= '0;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            sel_q  <= '1;
            fd_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pend_q <= pend_d;
            disp_q <= disp_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            sel_q  <= sel_d;
            fd_q   <= fd_d;
        end
    end

    assign seg_n      = seg_q;
    assign dp_n       = dp_q;
    assign dig_sel_n  = sel_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl with a cycle model
module tb_seg_scan_ctrl;
    localparam int ND = 4;
    localparam int SD = 8;
    localparam int BC = 2;
    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] sel;
        logic       fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dig_en = 4'hF;
    logic [3:0]  dp = 4'h0;
    logic        lz_blank = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_sel_n;
    logic        frame_done;

    exp_t        sb[$];
    int          t;
    logic [15:0] m_pend, m_disp;
    int          n_tot = 0;
    int          n_bad = 0;

    seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dig_en(dig_en), .dp(dp),
        .lz_blank(lz_blank), .seg_n(seg_n), .dp_n(dp_n), .dig_sel_n(dig_sel_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    always @(negedge clk) chk("onecold", 32'($countones(~dig_sel_n) <= 1), 32'd1);

    // model one clock: predict the pins produced by the coming edge, then compare
    task automatic step(input logic ld);
        exp_t e;
        int   mc, mi;
        logic show, sup, lit;
        mc   = t % SD;
        mi   = (t / SD) % ND;
        load = ld;
        show = mc >= BC;
        sup  = lz_blank && mi != 0;
        for (int k = mi; k < ND; k++)
            if (m_disp[4*k +: 4] != 4'h0) sup = 1'b0;
        lit   = show && dig_en[mi] && !sup;
        e.seg = lit ? SEG_TAB[m_disp[4*mi +: 4]] : 7'h7F;
        e.dp  = show ? !dp[mi] : 1'b1;
        e.sel = lit ? ~(4'b0001 << mi) : 4'hF;
        e.fd  = mc == SD - 1 && mi == ND - 1;
        sb.push_back(e);
        if (e.fd) m_disp = ld ? value : m_pend;
        if (ld) m_pend = value;
        t++;
        @(posedge clk);
        #1;
        load = 1'b0;
        e = sb.pop_front();
        chk("seg", 32'(seg_n), 32'(e.seg));
        chk("dp", 32'(dp_n), 32'(e.dp));
        chk("sel", 32'(dig_sel_n), 32'(e.sel));
        chk("fd", 32'(frame_done), 32'(e.fd));
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic model_reset();
        t = 0;
        m_pend = '0;
        m_disp = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        chk("rst_seg", 32'(seg_n), 32'h7F);
        chk("rst_dp", 32'(dp_n), 32'd1);
        chk("rst_sel", 32'(dig_sel_n), 32'hF);
        chk("rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(2);
        chk("first_dark", 32'(dig_sel_n), 32'hF);
        step(1'b0);
        chk("d0_sel", 32'(dig_sel_n), 32'b1110);
        chk("d0_seg", 32'(seg_n), 32'b1000000);
        run(29);
        run(2);
        value = 16'h1A3F;
        step(1'b1);
        run(29);
        run(3);
        chk("new_F", 32'(seg_n), 32'b0001110);
        run(29);
        value = 16'h0070;
        lz_blank = 1'b1;
        step(1'b1);
        run(31);
        run(11);
        chk("lz_7", 32'(seg_n), 32'b1111000);
        run(21);
        lz_blank = 1'b0;
        value = 16'h1A3F;
        dig_en = 4'b1011;
        dp = 4'b0010;
        step(1'b1);
        run(31);
        run(32);
        dig_en = 4'hF;
        dp = 4'h0;
        value = 16'h1234;
        step(1'b1);
        while (t % (SD * ND) != SD * ND - 1) step(1'b0);
        value = 16'h5555;
        step(1'b1);
        run(3);
        chk("bnd_new", 32'(seg_n), 32'h12);
        run(29);
        while (t % SD != 4) step(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(seg_n), 32'h7F);
        chk("mid_rst_dp", 32'(dp_n), 32'd1);
        chk("mid_rst_sel", 32'(dig_sel_n), 32'hF);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(2);
        chk("restart_dark", 32'(dig_sel_n), 32'hF);
        step(1'b0);
        chk("restart_sel", 32'(dig_sel_n), 32'b1110);
        chk("restart_seg", 32'(seg_n), 32'b1000000);
        run(40);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
